// File: rtl/noc_pkt_pkg.sv
// Flit field layout, payload sizing and per-VC state encoding for the VC packet format.
// No logic of its own; helpers are constant functions evaluated at elaboration.
// No flow control of its own.
package noc_pkt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ASM  = 2'd1,
        DONE = 2'd2
    } vc_state_e;

    // Bit positions counted from the flit MSB: valid, head, tail, then the VC id.
    function automatic int valid_bit(input int fw);
        return fw - 1;
    endfunction

    function automatic int head_bit(input int fw);
        return fw - 2;
    endfunction

    function automatic int tail_bit(input int fw);
        return fw - 3;
    endfunction

    function automatic int vc_msb(input int fw);
        return fw - 4;
    endfunction

    // Payload carried by the head flit (dest field eats into it).
    function automatic int p1_w(input int fw, input int aw, input int vw);
        return fw - 3 - aw - vw;
    endfunction

    // Payload carried by every body/tail flit.
    function automatic int pk_w(input int fw, input int vw);
        return fw - 3 - vw;
    endfunction

    // Flits needed to carry one data word (1..4 for legal parameter sets).
    function automatic int num_flits(input int fw, input int aw, input int vw, input int dw);
        int p1;
        int pk;
        p1 = p1_w(fw, aw, vw);
        pk = pk_w(fw, vw);
        if (dw <= p1) begin
            return 1;
        end
        return 1 + (dw - p1 + pk - 1) / pk;
    endfunction

endpackage

// File: rtl/depacketizer_vc_if.sv
// Flit-in / word-out bundle of the depacketizer.
// Pure wiring, no latency.
// Flit side: per-VC accept in i_ready_out; word side: valid/ready.
interface depacketizer_vc_if #(
    parameter int ADDRESS_WIDTH    = 4,
    parameter int VC_ADDRESS_WIDTH = 1,
    parameter int WIDTH_PKT        = 36,
    parameter int WIDTH_DATA       = 12
);
    localparam int FLIT_WIDTH = WIDTH_PKT / 4;
    localparam int NUM_VC     = 2 ** VC_ADDRESS_WIDTH;

    logic [FLIT_WIDTH-1:0]       i_flit_in;
    logic                        i_valid_in;
    logic [NUM_VC-1:0]           i_ready_out;
    logic [WIDTH_DATA-1:0]       o_data_out;
    logic [ADDRESS_WIDTH-1:0]    o_dest_out;
    logic [VC_ADDRESS_WIDTH-1:0] o_vc_out;
    logic                        o_valid_out;
    logic                        o_ready_in;
    logic                        o_err;

    // Depacketizer side.
    modport slave (
        input  i_flit_in, i_valid_in, o_ready_in,
        output i_ready_out, o_data_out, o_dest_out, o_vc_out, o_valid_out, o_err
    );

    // Router / fabric side.
    modport master (
        output i_flit_in, i_valid_in, o_ready_in,
        input  i_ready_out, o_data_out, o_dest_out, o_vc_out, o_valid_out, o_err
    );
endinterface

// File: rtl/depkt_vc_assembler.sv
// One VC's reassembly buffer: collects head/body/tail payload chunks into a data word.
// Word valid the cycle after its tail is accepted; error flag pulses the cycle after a bad flit.
// Holds in DONE until drained; a flit arriving in the drain cycle is taken as if IDLE.
module depkt_vc_assembler
    import noc_pkt_pkg::*;
#(
    parameter int ADDRESS_WIDTH    = 4,
    parameter int VC_ADDRESS_WIDTH = 1,
    parameter int WIDTH_PKT        = 36,
    parameter int WIDTH_DATA       = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flit_vld,
    input  logic                     flit_head,
    input  logic                     flit_tail,
    input  logic [ADDRESS_WIDTH-1:0] flit_dest,
    input  logic [pk_w(WIDTH_PKT/4, VC_ADDRESS_WIDTH)-1:0] flit_pay,
    input  logic                     drain,
    output logic                     word_vld,
    output logic [WIDTH_DATA-1:0]    word_dat,
    output logic [ADDRESS_WIDTH-1:0] word_dest,
    output logic                     err
);
    localparam int FW    = WIDTH_PKT / 4;
    localparam int P1    = p1_w(FW, ADDRESS_WIDTH, VC_ADDRESS_WIDTH);
    localparam int PK    = pk_w(FW, VC_ADDRESS_WIDTH);
    localparam int NF    = num_flits(FW, ADDRESS_WIDTH, VC_ADDRESS_WIDTH, WIDTH_DATA);
    // Chunks are shifted in MSB-first, so after NF flits the word sits at the top.
    localparam int ACC_W = P1 + (NF - 1) * PK;
    localparam logic [2:0] NF_C = 3'(NF);

    vc_state_e                state_q, state_d, cur_st;
    logic [2:0]               cnt_q, cnt_d, cnt_inc;
    logic [ACC_W-1:0]         acc_q, acc_d;
    logic [ADDRESS_WIDTH-1:0] dest_q, dest_d;
    logic                     err_q, err_d;

    assign cnt_inc   = cnt_q + 3'd1;
    assign word_vld  = (state_q == DONE);
    assign word_dat  = acc_q[ACC_W-1 -: WIDTH_DATA];
    assign word_dest = dest_q;
    assign err       = err_q;

    // Next state: drain frees the buffer first, then the incoming flit is applied.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        dest_d  = dest_q;
        err_d   = 1'b0;
        cur_st  = state_q;
        if (state_q == DONE && drain) begin
            cur_st  = IDLE;
            state_d = IDLE;
            cnt_d   = 3'd0;
        end
        if (flit_vld) begin
            if (flit_head) begin
                // A head always starts over; a head over a partial packet is an error.
                err_d  = (cur_st == ASM);
                dest_d = flit_dest;
                acc_d  = ACC_W'(flit_pay[P1-1:0]);
                cnt_d  = 3'd1;
                if (!flit_tail) begin
                    state_d = ASM;
                end else if (NF == 1) begin
                    state_d = DONE;
                end else begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                    cnt_d   = 3'd0;
                end
            end else begin
                case (cur_st)
                    IDLE: err_d = 1'b1;
                    ASM: begin
                        acc_d = (acc_q << PK) | ACC_W'(flit_pay);
                        cnt_d = cnt_inc;
                        if (flit_tail) begin
                            if (cnt_inc == NF_C) begin
                                state_d = DONE;
                            end else begin
                                err_d   = 1'b1;
                                state_d = IDLE;
                                cnt_d   = 3'd0;
                            end
                        end else if (cnt_inc == 3'd4) begin
                            err_d   = 1'b1;
                            state_d = IDLE;
                            cnt_d   = 3'd0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // State, count, buffers and error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            acc_q   <= '0;
            dest_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            dest_q  <= dest_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: rtl/depacketizer_vc.sv
// Demuxes router flits to per-VC assemblers and drains finished words round-robin.
// Tail accepted at cycle t gives o_valid_out at t+1; o_err one cycle after the bad flit.
// A VC holding a finished word refuses flits unless that word drains this cycle; grant frozen while stalled.
module depacketizer_vc
    import noc_pkt_pkg::*;
#(
    parameter int ADDRESS_WIDTH    = 4,
    parameter int VC_ADDRESS_WIDTH = 1,
    parameter int WIDTH_PKT        = 36,
    parameter int WIDTH_DATA       = 12
) (
    input  logic               clk,
    input  logic               rst,
    depacketizer_vc_if.slave   bus
);
    localparam int FW     = WIDTH_PKT / 4;
    localparam int VW     = VC_ADDRESS_WIDTH;
    localparam int NUM_VC = 2 ** VW;
    localparam int PK     = pk_w(FW, VW);

    logic                     flit_ok;
    logic [VW-1:0]            flit_vc;
    logic [NUM_VC-1:0]        vc_take, vc_done, vc_drain, vc_err, vc_rdy, gnt_oh;
    logic [WIDTH_DATA-1:0]    vc_dat  [NUM_VC];
    logic [ADDRESS_WIDTH-1:0] vc_dest [NUM_VC];

    logic [VW-1:0] rr_q, rr_d, gnt_q, gnt_d, gnt_idx, scan_idx;
    logic          hold_q, hold_d, found, any_done, hs;

    // Flits with the in-band valid bit clear are ignored outright.
    assign flit_ok = bus.i_valid_in & bus.i_flit_in[valid_bit(FW)];
    assign flit_vc = bus.i_flit_in[vc_msb(FW) -: VW];

    for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
        assign gnt_oh[v]   = (gnt_idx == VW'(v));
        assign vc_rdy[v]   = ~vc_done[v] | (gnt_oh[v] & bus.o_ready_in);
        assign vc_take[v]  = flit_ok & (flit_vc == VW'(v)) & vc_rdy[v];
        assign vc_drain[v] = vc_done[v] & gnt_oh[v] & bus.o_ready_in;

        depkt_vc_assembler #(
            .ADDRESS_WIDTH    (ADDRESS_WIDTH),
            .VC_ADDRESS_WIDTH (VC_ADDRESS_WIDTH),
            .WIDTH_PKT        (WIDTH_PKT),
            .WIDTH_DATA       (WIDTH_DATA)
        ) u_asm (
            .clk       (clk),
            .rst       (rst),
            .flit_vld  (vc_take[v]),
            .flit_head (bus.i_flit_in[head_bit(FW)]),
            .flit_tail (bus.i_flit_in[tail_bit(FW)]),
            .flit_dest (bus.i_flit_in[vc_msb(FW)-VW -: ADDRESS_WIDTH]),
            .flit_pay  (bus.i_flit_in[PK-1:0]),
            .drain     (vc_drain[v]),
            .word_vld  (vc_done[v]),
            .word_dat  (vc_dat[v]),
            .word_dest (vc_dest[v]),
            .err       (vc_err[v])
        );
    end

    // Round-robin pick starting at the pointer; a stalled grant is reused unchanged.
    always_comb begin
        found    = 1'b0;
        gnt_idx  = rr_q;
        scan_idx = rr_q;
        for (int i = 0; i < NUM_VC; i++) begin
            scan_idx = rr_q + VW'(i);
            if (!found && vc_done[scan_idx]) begin
                gnt_idx = scan_idx;
                found   = 1'b1;
            end
        end
        if (hold_q) begin
            gnt_idx = gnt_q;
        end
    end

    assign any_done        = |vc_done;
    assign hs              = any_done & bus.o_ready_in;
    assign bus.o_valid_out = any_done;
    assign bus.o_data_out  = vc_dat[gnt_idx];
    assign bus.o_dest_out  = vc_dest[gnt_idx];
    assign bus.o_vc_out    = gnt_idx;
    assign bus.i_ready_out = vc_rdy;
    assign bus.o_err       = |vc_err;

    // Pointer moves past the winner only on a handshake; remember a stalled grant.
    always_comb begin
        rr_d   = rr_q;
        gnt_d  = gnt_idx;
        hold_d = any_done & ~bus.o_ready_in;
        if (hs) begin
            rr_d = gnt_idx + VW'(1);
        end
    end

    // Arbiter state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q   <= '0;
            gnt_q  <= '0;
            hold_q <= 1'b0;
        end else begin
            rr_q   <= rr_d;
            gnt_q  <= gnt_d;
            hold_q <= hold_d;
        end
    end

endmodule

// File: tb/tb_depacketizer_vc.sv
module tb_depacketizer_vc;

    typedef struct {
        logic [8:0]  flit;
        logic        vin;
        logic        rin;
        logic        evld;
        logic [11:0] edata;
        logic [3:0]  edest;
        logic        evc;
        logic [1:0]  erdy;
        logic        eerr;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    vec_t vecs[$];
    vec_t cur;

    depacketizer_vc_if bus ();

    depacketizer_vc dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [8:0] fh(input logic vc, input logic [3:0] d, input logic p);
        return {3'b110, vc, d, p};
    endfunction

    function automatic logic [8:0] fb(input logic vc, input logic [4:0] p);
        return {3'b100, vc, p};
    endfunction

    function automatic logic [8:0] ft(input logic vc, input logic [4:0] p);
        return {3'b101, vc, p};
    endfunction

    task automatic chk(input string name, input int step, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, step, act, exp);
        end
    endtask

    task automatic add(input logic [8:0] f, input logic vin, input logic rin, input logic evld,
                       input logic [11:0] ed, input logic [3:0] edst, input logic evc,
                       input logic [1:0] erdy, input logic eerr);
        vec_t v;
        v.flit = f; v.vin = vin; v.rin = rin; v.evld = evld; v.edata = ed;
        v.edest = edst; v.evc = evc; v.erdy = erdy; v.eerr = eerr;
        vecs.push_back(v);
    endtask

    // Step with nothing expected on the output side.
    task automatic nx(input logic [8:0] f, input logic vin, input logic rin);
        add(f, vin, rin, 1'b0, 12'h0, 4'h0, 1'b0, 2'b11, 1'b0);
    endtask

    task automatic drive(input logic [8:0] f, input logic vin, input logic rin);
        @(negedge clk);
        bus.i_flit_in  = f;
        bus.i_valid_in = vin;
        bus.o_ready_in = rin;
        #2;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        bus.i_flit_in  = '0;
        bus.i_valid_in = 1'b0;
        bus.o_ready_in = 1'b0;

        // Test 1: word A5C, dest 3, VC0.
        nx(9'b110000111, 1, 1);
        nx(9'b100001001, 1, 1);
        nx(9'b100001110, 1, 1);
        nx(9'b101000000, 1, 1);
        add(9'h0, 0, 1, 1, 12'hA5C, 4'h3, 0, 2'b11, 0);
        nx(9'h0, 0, 1);
        // Test 2: VC0 123 dest 5 interleaved with VC1 FED dest A.
        nx(fh(0, 4'h5, 1'b0), 1, 1);
        nx(fh(1, 4'hA, 1'b1), 1, 1);
        nx(fb(0, 5'b00100), 1, 1);
        nx(fb(1, 5'b11111), 1, 1);
        nx(fb(0, 5'b10001), 1, 1);
        nx(fb(1, 5'b10110), 1, 1);
        nx(ft(0, 5'b10000), 1, 1);
        add(ft(1, 5'b10000), 1, 1, 1, 12'h123, 4'h5, 0, 2'b11, 0);
        add(9'h0, 0, 1, 1, 12'hFED, 4'hA, 1, 2'b11, 0);
        nx(9'h0, 0, 1);
        // Test 3: consumer stalled with VC0 DONE (5A5 dest 6); VC1 keeps accepting.
        nx(fh(0, 4'h6, 1'b0), 1, 0);
        nx(fb(0, 5'b10110), 1, 0);
        nx(fb(0, 5'b10010), 1, 0);
        nx(ft(0, 5'b10000), 1, 0);
        add(fh(1, 4'hC, 1'b0), 1, 0, 1, 12'h5A5, 4'h6, 0, 2'b10, 0);
        add(fh(0, 4'h1, 1'b1), 1, 0, 1, 12'h5A5, 4'h6, 0, 2'b10, 0);
        add(9'h0, 0, 1, 1, 12'h5A5, 4'h6, 0, 2'b11, 0);
        nx(9'h0, 0, 0);
        nx(fb(1, 5'b00011), 1, 0);
        nx(fb(1, 5'b11000), 1, 0);
        nx(ft(1, 5'b00000), 1, 0);
        add(9'h0, 0, 1, 1, 12'h0F0, 4'hC, 1, 2'b11, 0);
        nx(9'h0, 0, 1);
        // Test 4: body on idle VC1, then head mid-packet on VC0 (C3A dest 9).
        nx(fb(1, 5'h15), 1, 1);
        add(9'h0, 0, 1, 0, 12'h0, 4'h0, 0, 2'b11, 1);
        nx(9'h0, 0, 1);
        nx(fh(0, 4'h2, 1'b1), 1, 1);
        nx(fb(0, 5'b11111), 1, 1);
        nx(fh(0, 4'h9, 1'b1), 1, 1);
        add(fb(0, 5'b10000), 1, 1, 0, 12'h0, 4'h0, 0, 2'b11, 1);
        nx(fb(0, 5'b11101), 1, 1);
        nx(ft(0, 5'b00000), 1, 1);
        add(9'h0, 0, 1, 1, 12'hC3A, 4'h9, 0, 2'b11, 0);
        nx(9'h0, 0, 1);
        // Test 5: early tail on VC1, invalid flit, then a clean VC1 packet (7E1 dest F).
        nx(fh(1, 4'h4, 1'b0), 1, 1);
        nx(fb(1, 5'b00001), 1, 1);
        nx(ft(1, 5'b00000), 1, 1);
        add(9'h0, 0, 1, 0, 12'h0, 4'h0, 0, 2'b11, 1);
        nx(9'b001100000, 1, 1);
        nx(9'h0, 0, 1);
        nx(fh(1, 4'hF, 1'b0), 1, 1);
        nx(fb(1, 5'b11111), 1, 1);
        nx(fb(1, 5'b10000), 1, 1);
        nx(ft(1, 5'b10000), 1, 1);
        add(9'h0, 0, 1, 1, 12'h7E1, 4'hF, 1, 2'b11, 0);
        nx(9'h0, 0, 1);
        // Back-to-back on VC0: next head lands in the drain cycle of 001.
        nx(fh(0, 4'h1, 1'b0), 1, 1);
        nx(fb(0, 5'b00000), 1, 1);
        nx(fb(0, 5'b00000), 1, 1);
        nx(ft(0, 5'b10000), 1, 1);
        add(fh(0, 4'h2, 1'b1), 1, 1, 1, 12'h001, 4'h1, 0, 2'b11, 0);
        nx(fb(0, 5'b00000), 1, 1);
        nx(fb(0, 5'b00000), 1, 1);
        nx(ft(0, 5'b00000), 1, 1);
        add(9'h0, 0, 1, 1, 12'h800, 4'h2, 0, 2'b11, 0);
        nx(9'h0, 0, 1);

        repeat (2) @(negedge clk);
        rst = 1'b0;
        #2;
        chk("reset_valid", -1, bus.o_valid_out, 1'b0);
        chk("reset_err", -1, bus.o_err, 1'b0);
        chk("reset_ready", -1, bus.i_ready_out, 2'b11);

        for (int k = 0; k < vecs.size(); k++) begin
            cur = vecs[k];
            drive(cur.flit, cur.vin, cur.rin);
            chk("valid", k, bus.o_valid_out, cur.evld);
            chk("ready", k, bus.i_ready_out, cur.erdy);
            chk("err", k, bus.o_err, cur.eerr);
            if (cur.evld) begin
                chk("data", k, bus.o_data_out, cur.edata);
                chk("dest", k, bus.o_dest_out, cur.edest);
                chk("vc", k, bus.o_vc_out, cur.evc);
            end
        end

        // Test 6: reset with VC1 DONE and VC0 mid-assembly, then a fresh packet.
        drive(fh(1, 4'hC, 1'b0), 1, 0);
        drive(fb(1, 5'b00011), 1, 0);
        drive(fb(1, 5'b11000), 1, 0);
        drive(ft(1, 5'b00000), 1, 0);
        drive(fh(0, 4'h3, 1'b1), 1, 0);
        chk("rst_pre_valid", 100, bus.o_valid_out, 1'b1);
        chk("rst_pre_vc", 100, bus.o_vc_out, 1'b1);
        drive(fb(0, 5'b01001), 1, 0);
        rst = 1'b1;
        bus.i_valid_in = 1'b0;
        #1;
        chk("rst_async_valid", 101, bus.o_valid_out, 1'b0);
        chk("rst_async_err", 101, bus.o_err, 1'b0);
        chk("rst_async_ready", 101, bus.i_ready_out, 2'b11);
        drive(9'h0, 0, 0);
        rst = 1'b0;
        drive(9'b110000111, 1, 1);
        drive(9'b100001001, 1, 1);
        drive(9'b100001110, 1, 1);
        chk("post_rst_busy", 102, bus.o_valid_out, 1'b0);
        drive(9'b101000000, 1, 1);
        drive(9'h0, 0, 1);
        chk("post_rst_valid", 103, bus.o_valid_out, 1'b1);
        chk("post_rst_data", 103, bus.o_data_out, 12'hA5C);
        chk("post_rst_dest", 103, bus.o_dest_out, 4'h3);
        chk("post_rst_vc", 103, bus.o_vc_out, 1'b0);
        drive(9'h0, 0, 1);
        chk("post_rst_drained", 104, bus.o_valid_out, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/depacketizer_vc.md
Name: depacketizer_vc

Overview:
Receive end of the VC packet format: accepts flits one per cycle from a NoC router output port, possibly interleaved across VCs. Reassembles each VC's flits into one data word, recovers destination and VC, and presents completed words on a ready/valid output to the fabric port out-side. Each VC has one assembly buffer; completed words are drained round-robin.

Parameters:
ADDRESS_WIDTH, 4, router address field width in head flit
VC_ADDRESS_WIDTH, 1, VC id width; NUM_VC = 2**VC_ADDRESS_WIDTH
WIDTH_PKT, 36, packet width; FLIT_WIDTH = WIDTH_PKT/4
WIDTH_DATA, 12, reassembled data width

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
i_flit_in  input  FLIT_WIDTH  flit from router
i_valid_in  input  1  flit strobe
i_ready_out  output  NUM_VC  per-VC accept; flit accepted iff i_valid_in & i_ready_out[flit vc]
o_data_out  output  WIDTH_DATA  reassembled word
o_dest_out  output  ADDRESS_WIDTH  dest field from head flit
o_vc_out  output  VC_ADDRESS_WIDTH  VC of presented word
o_valid_out  output  1  word available
o_ready_in  input  1  consumer accept
o_err  output  1  one-cycle pulse on protocol error

Behaviour:
- Reset: asynchronous active-high; all VC states IDLE, buffers and counters 0, RR pointer 0, o_valid_out=0, o_err=0, i_ready_out all 1 after reset release.
- Flit fields, MSB first: valid, head, tail, vc[VC_ADDRESS_WIDTH]; head flit then dest[ADDRESS_WIDTH]; then payload, zero-padded at LSBs.
- Payload widths: P1 = FLIT_WIDTH-3-ADDRESS_WIDTH-VC_ADDRESS_WIDTH; Pk = FLIT_WIDTH-3-VC_ADDRESS_WIDTH for k=2..4. Data is MSB-first: flit1 takes the top min(P1,WIDTH_DATA) bits, each later flit takes the next chunk. NUM_FLITS = flits needed, range 1..4.
- Flit with valid bit 0 while i_valid_in=1: ignored, not counted, no error.
- Per-VC FSM: IDLE -> (head) ASM, or IDLE -> (head & tail & NUM_FLITS==1) DONE. ASM -> (body/tail) ASM with count+1. ASM -> (tail & count+1==NUM_FLITS) DONE. DONE -> (granted & o_ready_in) IDLE.
- Error cases, each pulses o_err next cycle:
  - body/tail in IDLE: dropped.
  - head in ASM: discard partial, restart with new head.
  - tail with wrong count, or count reaching 4 without tail: discard, return to IDLE.
- i_ready_out[v] = (state[v]!=DONE) | (grant[v] & o_ready_in). Allows back-to-back packets on one VC with no bubble.
- Output arbitration:
  - o_valid_out = any VC in DONE; data, dest and vc muxed from the granted buffer.
  - Grant is round-robin starting at RR pointer; pointer advances past the granted VC on handshake only.
  - Grant is held stable while o_valid_out & !o_ready_in.
- Latency: tail accepted at cycle t -> o_valid_out=1 at t+1.
- Simultaneous events: a flit for VC a and a drain of VC b in the same cycle are independent. Draining VC v while its next head arrives loads that head in the same cycle.

Decomposition:
- Package noc_pkt_pkg: field offset constants, P1/Pk/NUM_FLITS functions of the parameters, per-VC state enum {IDLE, ASM, DONE}.
- Sub-module depkt_vc_assembler: one per VC, holding FSM, count, data/dest buffer and error flag.
- Top level: flit demux, RR arbiter, output mux, error OR.

Test Plan:
1. Defaults, word 12'hA5C, dest 4'h3, VC0:
   - Flits: head {1,1,0,0,0011,1}; body {1,0,0,0,01001}; body {1,0,0,0,01110}; tail {1,0,1,0,00000}, one per cycle.
   - Required: o_valid_out one cycle after the tail, with o_data_out=12'hA5C, o_dest_out=3, o_vc_out=0.
2. Interleave VC0 and VC1 packets flit by flit, data 12'h123 and 12'hFED -> both words delivered intact; the RR order follows completion, then the pointer.
3. Hold o_ready_in=0 with VC0 DONE -> i_ready_out[0]=0 and i_ready_out[1]=1; a VC0 flit is not accepted; outputs stay stable. Raise o_ready_in -> word drained and i_ready_out[0]=1 in the same cycle.
4. Body flit on idle VC1 -> dropped, o_err pulses once, no output. Head arriving mid-packet on VC0 -> restart; the new packet completes correctly.
5. Tail after 2 flits, NUM_FLITS=4 -> o_err pulse, no output, VC returns to IDLE.
6. Assert rst mid-assembly with VC1 DONE -> o_valid_out=0 immediately. After release, a fresh packet assembles normally.
